// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command issue stage for the accumulator ALU with div-by-zero and error halting
module alu_cmd_sequencer #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [OP_W-1:0]            cmd_opcode,
  input  logic [DATA_W-1:0]          cmd_operand,
  output logic [OP_W-1:0]            alu_opcode,
  output logic [DATA_W-1:0]          alu_A,
  input  logic                       alu_err,
  input  logic                       halt_clr,
  output logic                       halted,
  output logic [1:0]                 err_code,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           issued_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
  state_t            r_state;
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_level;
  logic [OP_W-1:0]   r_mem_op [DEPTH];
  logic [DATA_W-1:0] r_mem_a  [DEPTH];
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_a;
  logic [1:0]        r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_push, w_pop, w_divz;
  logic [OP_W-1:0]   w_head_op;
  logic [DATA_W-1:0] w_head_a;
  logic [AW:0]       w_level_nx;
  assign cmd_ready  = r_level != (AW+1)'(DEPTH);
  assign w_push     = cmd_valid && cmd_ready;
  assign w_head_op  = r_mem_op[r_rp];
  assign w_head_a   = r_mem_a[r_rp];
  assign w_divz     = (w_head_op == OP_W'(4) || w_head_op == OP_W'(5)) && w_head_a == '0;
  // A pending ALU error or HALT blocks the pop; a div-by-zero head is still popped (and discarded)
  assign w_pop      = r_state != S_HALT && !alu_err && r_level != '0;
  assign w_level_nx = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign alu_opcode = r_op;
  assign alu_A      = r_a;
  assign halted     = r_state == S_HALT;
  assign err_code   = r_err;
  assign level      = r_level;
  assign issued_cnt = r_cnt;
  assign busy       = r_level != '0 || r_op != '0;
  // FIFO storage, written on accepted commands
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wp] <= cmd_opcode;
      r_mem_a[r_wp]  <= cmd_operand;
    end
  end
  // Pointer/level bookkeeping plus the issue FSM in priority order: ALU error, HALT, div-by-zero, issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_err   <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_level <= w_level_nx;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_op <= '0;
      r_a  <= '0;
      if (alu_err && r_state != S_HALT) begin
        r_state <= S_HALT;
        r_err   <= 2'b01;
      end else if (r_state == S_HALT) begin
        if (halt_clr) begin
          r_state <= w_level_nx != '0 ? S_RUN : S_IDLE;
          r_err   <= 2'b00;
        end
      end else if (w_pop && w_divz) begin
        r_state <= S_HALT;
        r_err   <= 2'b10;
      end else begin
        r_state <= w_level_nx != '0 ? S_RUN : S_IDLE;
        if (w_pop) begin
          r_op  <= w_head_op;
          r_a   <= w_head_a;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: randomized and directed checks of alu_cmd_sequencer against a queue-based model
module tb_alu_cmd_sequencer;
  logic        clk = 0, reset = 1, cmd_valid = 0, alu_err = 0, halt_clr = 0;
  logic        cmd_ready, halted, busy;
  logic [3:0]  cmd_opcode = 0, alu_opcode, issued_cnt;
  logic [31:0] cmd_operand = 0, alu_A;
  logic [1:0]  err_code;
  logic [2:0]  level;
  int total = 0, bad = 0;

  alu_cmd_sequencer #(.DATA_W(32), .OP_W(4), .DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand), .alu_opcode(alu_opcode),
    .alu_A(alu_A), .alu_err(alu_err), .halt_clr(halt_clr), .halted(halted),
    .err_code(err_code), .busy(busy), .level(level), .issued_cnt(issued_cnt));

  always #5 clk = ~clk;

  wire [47:0] dut_vec = {alu_opcode, alu_A, halted, err_code, level, issued_cnt, busy, cmd_ready};

  logic [3:0]  qo[$];
  logic [31:0] qa[$];
  logic [3:0]  m_op, m_cnt;
  logic [31:0] m_a;
  logic        m_halt, m_pu;
  logic [1:0]  m_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qo.delete(); qa.delete();
      m_op = 0; m_a = 0; m_halt = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_pu = cmd_valid && qo.size() != 4;
      m_op = 0; m_a = 0;
      if (alu_err && !m_halt) begin
        m_halt = 1; m_err = 1;
      end else if (m_halt) begin
        if (halt_clr) begin m_halt = 0; m_err = 0; end
      end else if (qo.size() != 0) begin
        if ((qo[0] == 4 || qo[0] == 5) && qa[0] == 0) begin m_halt = 1; m_err = 2; end
        else begin m_op = qo[0]; m_a = qa[0]; m_cnt = m_cnt + 1; end
        void'(qo.pop_front()); void'(qa.pop_front());
      end
      if (m_pu) begin qo.push_back(cmd_opcode); qa.push_back(cmd_operand); end
    end
  end

  function automatic logic [47:0] model_vec();
    logic [2:0] l = 3'(qo.size());
    return {m_op, m_a, m_halt, m_err, l, m_cnt, (l != 0 || m_op != 0), l != 4};
  endfunction

  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a, input logic e, input logic c);
    @(negedge clk);
    cmd_valid = v; cmd_opcode = op; cmd_operand = a; alu_err = e; halt_clr = c;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1; cmd_valid = 0; alu_err = 0; halt_clr = 0;
    @(negedge clk); reset = 0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (dut_vec !== 48'h1) begin bad++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 48'h1); end
    @(negedge clk); reset = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] acc = 0;
    logic [3:0] ops[3] = '{1, 2, 3};
    logic [31:0] as[3] = '{5, 1, 3};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) step(1, ops[i], as[i], 0, 0); else step(0, 0, 0, 0, 0);
      total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL b2b_model cyc=%0d got=%h exp=%h", i, dut_vec, model_vec()); end
      if (i >= 1 && i <= 3) begin
        total++; if (alu_opcode !== ops[i-1]) begin bad++; $display("FAIL b2b_op cyc=%0d got=%h exp=%h", i, alu_opcode, ops[i-1]); end
      end
      acc = alu_opcode == 1 ? acc + alu_A : alu_opcode == 2 ? acc - alu_A : alu_opcode == 3 ? acc * alu_A : acc;
    end
    total++; if (acc !== 32'd12) begin bad++; $display("FAIL b2b_acc got=%0d exp=12", acc); end
    total++; if (issued_cnt !== 4'd3 || busy !== 1'b0) begin bad++; $display("FAIL b2b_end cnt=%0d busy=%b exp cnt=3 busy=0", issued_cnt, busy); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      step(1, 4'd1, 32'(i + 1), 1, 0);
      total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL full_model cyc=%0d got=%h exp=%h", i, dut_vec, model_vec()); end
    end
    total++; if (level !== 3'd4 || cmd_ready !== 1'b0 || halted !== 1'b1 || err_code !== 2'b01) begin
      bad++; $display("FAIL full_state level=%0d ready=%b halted=%b err=%b exp 4 0 1 01", level, cmd_ready, halted, err_code); end
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL full_drain cyc=%0d got=%h exp=%h", i, dut_vec, model_vec()); end
    end
  endtask

  task automatic test_divzero();
    step(1, 4'd4, 0, 0, 0);
    step(1, 4'd1, 2, 0, 0);
    total++; if (halted !== 1'b1 || err_code !== 2'b10 || alu_opcode !== 4'd0 || level !== 3'd1) begin
      bad++; $display("FAIL divz_halt halted=%b err=%b op=%h level=%0d exp 1 10 0 1", halted, err_code, alu_opcode, level); end
    step(0, 0, 0, 0, 1);
    total++; if (halted !== 1'b0 || err_code !== 2'b00 || alu_opcode !== 4'd0) begin
      bad++; $display("FAIL divz_clr halted=%b err=%b op=%h exp 0 00 0", halted, err_code, alu_opcode); end
    step(0, 0, 0, 0, 0);
    total++; if (alu_opcode !== 4'd1 || alu_A !== 32'd2 || dut_vec !== model_vec()) begin
      bad++; $display("FAIL divz_issue got=%h exp=%h", dut_vec, model_vec()); end
  endtask

  task automatic test_alu_err();
    step(0, 0, 0, 1, 0);
    step(1, 4'd2, 7, 0, 0);
    step(1, 4'd3, 9, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    total++; if (level !== 3'd2 || halted !== 1'b1 || err_code !== 2'b01 || dut_vec !== model_vec()) begin
      bad++; $display("FAIL err_hold got=%h exp=%h", dut_vec, model_vec()); end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 4'd5, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    total++; if (level !== 3'd1 || err_code !== 2'b01 || dut_vec !== model_vec()) begin
      bad++; $display("FAIL err_vs_divz got=%h exp=%h", dut_vec, model_vec()); end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    total++; if (err_code !== 2'b10 || level !== 3'd0 || dut_vec !== model_vec()) begin
      bad++; $display("FAIL divz_after_err got=%h exp=%h", dut_vec, model_vec()); end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 4'd15, 32'(i), 0, 0);
    total++; if (level !== 3'd3) begin bad++; $display("FAIL areset_pre level=%0d exp=3", level); end
    @(posedge clk); #3; reset = 1; #1;
    total++; if (dut_vec !== 48'h1) begin bad++; $display("FAIL areset got=%h exp=%h", dut_vec, 48'h1); end
    @(negedge clk); reset = 0; cmd_valid = 0;
    step(0, 0, 0, 0, 0);
    total++; if (dut_vec !== 48'h1) begin bad++; $display("FAIL areset_empty got=%h exp=%h", dut_vec, 48'h1); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 4'(i), 32'(i + 1), 0, 0);
    step(0, 0, 0, 0, 0);
    total++; if (issued_cnt !== 4'd1 || dut_vec !== model_vec()) begin
      bad++; $display("FAIL wrap cnt=%0d exp=1 got=%h exp=%h", issued_cnt, dut_vec, model_vec()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      logic [3:0] op = ($urandom % 3 == 0) ? 4'(4 + $urandom % 2) : 4'($urandom);
      step($urandom % 4 != 0, op, ($urandom % 3 == 0) ? 32'd0 : $urandom,
           $urandom % 25 == 0, $urandom % 3 == 0);
      total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, model_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_divzero();
    test_alu_err();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
